// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared types and constants for the RV32M multiply/divide sequencer
package muldiv_sequencer_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  // func7 value that marks an M-extension op in the decoder
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  // Two's complement negate when neg is set
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - EX-stage handshake between pipeline control and the sequencer
interface muldiv_sequencer_if;
  import muldiv_sequencer_pkg::*;

  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, func3, operand_a, operand_b, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, func3, operand_a, operand_b, flush,
    output stall, busy, done, result
  );

endinterface

// File: rtl/muldiv_sequencer_iter_datapath.sv
// rtl/muldiv_sequencer_iter_datapath.sv - one shift-add or restoring-divide step per cycle
module muldiv_iter_datapath
  import muldiv_sequencer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              div_i,
  input  logic [2*XLEN-1:0] init_acc_i,
  input  logic [XLEN-1:0]   divisor_i,
  output logic [2*XLEN-1:0] acc_o
);

  // Upper half: running product high word / partial remainder.
  // Lower half: multiplier bits still to consume / dividend bits then quotient bits.
  logic [2*XLEN-1:0] acc_d, acc_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     trial_rem;
  logic [XLEN-1:0]   trial_diff;
  logic              trial_ok;

  // Next accumulator: load, or one multiply/divide iteration
  always_comb begin
    mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    trial_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    trial_ok   = (trial_rem >= {1'b0, b_q});
    // The remainder stays below the divisor, so a passing trial fits in XLEN bits
    trial_diff = trial_rem[XLEN-1:0] - b_q;
    acc_d      = acc_q;
    if (load_i) begin
      acc_d = init_acc_i;
    end else if (step_i) begin
      if (!div_i)
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      else if (trial_ok)
        acc_d = {trial_diff, acc_q[XLEN-2:0], 1'b1};
      else
        acc_d = {trial_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  // Accumulator and held divisor/multiplicand registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      if (load_i) b_q <= divisor_i;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide sequencer with pipeline stall
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  muldiv_sequencer_if.slave bus
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  muldiv_op_e        op_q, op_in;
  logic              neg_q, neg_rem_q, op_is_div;
  logic [XLEN-1:0]   result_q, fix_val, mag_a, mag_b;
  logic              sign_a, sign_b, div_by_zero, overflow, special, accept, busy_step;
  logic [2*XLEN-1:0] init_acc, acc, prod;

  // Operand decode: signedness, magnitudes and the two divide corner cases
  always_comb begin
    op_in       = muldiv_op_e'(bus.func3);
    sign_a      = bus.operand_a[XLEN-1] & (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    sign_b      = bus.operand_b[XLEN-1] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
    mag_a       = cond_neg(bus.operand_a, sign_a);
    mag_b       = cond_neg(bus.operand_b, sign_b);
    div_by_zero = bus.func3[2] && (bus.operand_b == '0);
    overflow    = (op_in inside {OP_DIV, OP_REM}) && (bus.operand_a == INT_MIN) &&
                  (bus.operand_b == '1);
    special     = div_by_zero | overflow;
    accept      = (state_q == ST_IDLE) && bus.start && !bus.flush;
    // Corner cases preload the final quotient/remainder so DONE needs no extra path
    if (div_by_zero)   init_acc = {bus.operand_a, {XLEN{1'b1}}};
    else if (overflow) init_acc = {{XLEN{1'b0}}, INT_MIN};
    else               init_acc = {{XLEN{1'b0}}, mag_a};
  end

  assign op_is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign busy_step = (state_q == ST_BUSY);

  muldiv_iter_datapath u_datapath (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept),
    .step_i     (busy_step),
    .div_i      (op_is_div),
    .init_acc_i (init_acc),
    .divisor_i  (mag_b),
    .acc_o      (acc)
  );

  // Sign fix-up and selection of the architectural result word
  always_comb begin
    prod = neg_q ? -acc : acc;
    unique case (op_q)
      OP_MUL:                       fix_val = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_val = cond_neg(acc[XLEN-1:0], neg_q);
      default:                      fix_val = cond_neg(acc[2*XLEN-1:XLEN], neg_rem_q);
    endcase
  end

  // FSM next state and pipeline control outputs
  always_comb begin
    state_d   = state_q;
    bus.stall = 1'b0;
    bus.done  = 1'b0;
    bus.busy  = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        bus.stall = accept;
        if (accept) state_d = special ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        bus.stall = 1'b1;
        if (bus.flush)                        state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(XLEN - 1))   state_d = ST_DONE;
      end
      ST_DONE: begin
        bus.done = !bus.flush;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Present the fresh result during the done pulse, otherwise the held one
  assign bus.result = bus.done ? fix_val : result_q;

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Op latch, iteration counter and held result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        cnt_q     <= '0;
        op_q      <= op_in;
        neg_q     <= !special && (sign_a ^ sign_b);
        neg_rem_q <= !special && sign_a;
      end else if (busy_step) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (bus.done) result_q <= fix_val;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for the RV32M multiply/divide sequencer
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] last_res = '0;

  muldiv_sequencer_if bus ();

  muldiv_sequencer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics from plain 64-bit / signed arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb, q;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb;
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb;
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_short(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Issue one op; optionally flush at a given cycle after acceptance
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int flush_cyc);
    int lat, cyc;
    bit got, stall_ok, stall_at_done;
    logic [31:0] res;
    lat = is_short(op, a, b) ? 1 : 33;
    got = 0; stall_ok = 1; cyc = 0; res = '0; stall_at_done = 1;
    @(negedge clk);
    bus.start = 1'b1; bus.func3 = op; bus.operand_a = a; bus.operand_b = b;
    #1;
    check_eq("stall_on_accept", bus.stall, 1);
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      // A second start during the busy window must be ignored
      bus.start = (c == 5);
      if (c == 5) begin bus.func3 = 3'($urandom); bus.operand_a = $urandom; bus.operand_b = $urandom; end
      if (c == flush_cyc) begin
        bus.flush = 1'b1;
        #1;
        check_eq("done_under_flush", bus.done, 0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check_eq("idle_after_flush", bus.busy, 0);
        check_eq("result_kept_after_flush", bus.result, last_res);
        return;
      end
      #1;
      if (bus.done) begin
        got = 1; cyc = c; res = bus.result; stall_at_done = bus.stall;
      end else if (!bus.stall) begin
        stall_ok = 0;
      end
    end
    bus.start = 1'b0;
    if (!got) begin
      check_eq("done_timeout", 0, 1);
      return;
    end
    check_eq("latency", cyc, lat);
    check_eq($sformatf("result op%0d %h,%h", op, a, b), res, exp);
    check_eq("stall_while_busy", stall_ok, 1);
    check_eq("stall_in_done", stall_at_done, 0);
    @(negedge clk);
    #1;
    check_eq("done_single_pulse", bus.done, 0);
    check_eq("result_held", bus.result, exp);
    last_res = exp;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.flush = 1'b0; bus.func3 = '0; bus.operand_a = '0; bus.operand_b = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_stall", bus.stall, 0);
    check_eq("reset_busy", bus.busy, 0);
    check_eq("reset_done", bus.done, 0);
    check_eq("reset_result", bus.result, 0);
    rst = 1'b0;

    run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, -1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, -1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, -1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, -1);
    run_op(3'd5, 32'd7,        32'd2,        32'd3,        -1);
    run_op(3'd7, 32'd7,        32'd2,        32'd1,        -1);
    run_op(3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, -1);
    run_op(3'd7, 32'd5,        32'd0,        32'd5,        -1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        -1);

    // Flush mid-operation, then a fresh op is accepted
    run_op(3'd0, 32'd3, 32'd5, 32'd15, 10);
    run_op(3'd0, 32'd3, 32'd5, 32'd15, -1);

    // Flush beats start in the same idle cycle
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.func3 = 3'd0;
    #1;
    check_eq("flush_start_stall", bus.stall, 0);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    check_eq("flush_start_busy", bus.busy, 0);

    // Randomized ops with forced corner cases mixed in
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom); a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        default: ;
      endcase
      run_op(op, a, b, ref_model(op, a, b), -1);
    end

    // Asynchronous reset in the middle of a busy op
    @(negedge clk);
    bus.start = 1'b1; bus.func3 = 3'd4; bus.operand_a = 32'd1000; bus.operand_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_busy_stall", bus.stall, 0);
    check_eq("rst_busy_busy", bus.busy, 0);
    check_eq("rst_busy_done", bus.done, 0);
    check_eq("rst_busy_result", bus.result, 0);
    last_res = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd5, 32'd1000, 32'd7, 32'd142, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
